// File: rtl/parking_pkg.sv
// Shared parking constants and the exit-side state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package parking_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } exit_state_t;

endpackage

// File: rtl/exit_gate_timer.sv
// Gate hold counter and optional open-gate timeout counter (EXIT_TIMEOUT_EN).
// Latency: counters start at 0 on the first run cycle; flags are decoded from registered counts.
// Backpressure: none; run restarts both counters whenever it drops.
module exit_gate_timer #(
  parameter int GATE_HOLD = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic pass_seen,
  output logic hold_done,
  output logic timed_out
);

  localparam int HW = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(GATE_HOLD - 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // Hold count: restarts outside OPEN, saturates at the last required cycle.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!run) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Hold count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign hold_done = run && (hold_cnt_q == HOLD_LAST);

`ifdef EXIT_TIMEOUT_EN
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Timeout count: only cycles with no car seen yet; a car restarts it.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!run || pass_seen) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LAST) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Timeout count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timed_out = run && !pass_seen && (to_cnt_q == TO_LAST);
`else
  // Without the timeout the gate waits for a car indefinitely.
  logic          unused_pass_seen;
  logic [TW-1:0] unused_to_last;
  assign unused_pass_seen = pass_seen;
  assign unused_to_last   = TO_LAST;
  assign timed_out        = 1'b0;
`endif

endmodule

// File: rtl/exit_controller.sv
// Exit-lane controller: validates slot, releases occupancy bit, runs the barrier (timeout via EXIT_TIMEOUT_EN).
// Latency: ack 1 cycle after request, release/reject 2 cycles, done after GATE_HOLD open cycles + 1.
// Backpressure: exit_req ignored while exit_busy; a held request is taken on the first IDLE edge.
module exit_controller
  import parking_pkg::*;
#(
  parameter int GATE_HOLD = 16,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  input  logic [NUM_SLOTS-1:0] occupancy,
  input  logic                 car_passed,
  output logic                 exit_ack,
  output logic                 exit_busy,
  output logic                 slot_release,
  output logic [NUM_SLOTS-1:0] release_mask,
  output logic                 exit_reject,
  output logic                 gate_open,
  output logic                 exit_done,
  output logic [CNT_W-1:0]     exit_count,
  output logic                 exit_alarm
);

  exit_state_t          state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 rel_q, rel_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic                 rej_q, rej_d;
  logic                 gate_q, gate_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 passed_q, passed_d;
`ifdef EXIT_TIMEOUT_EN
  logic                 alarm_q, alarm_d;
`endif

  logic                 slot_ok;
  logic [NUM_SLOTS-1:0] slot_onehot;
  logic                 pass_now;
  logic                 hold_done;
  logic                 timed_out;

  exit_gate_timer #(
    .GATE_HOLD (GATE_HOLD),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state_q == OPEN),
    .pass_seen (pass_now),
    .hold_done (hold_done),
    .timed_out (timed_out)
  );

  assign pass_now = passed_q | car_passed;

  // Decode the latched slot; an index with no matching bit is simply not valid.
  always_comb begin
    slot_ok     = 1'b0;
    slot_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        slot_onehot[i] = 1'b1;
        slot_ok        = occupancy[i];
      end
    end
  end

  // Next-state and next-output logic; every output is a flop.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    ack_d    = 1'b0;
    rel_d    = 1'b0;
    mask_d   = '0;
    rej_d    = 1'b0;
    gate_d   = gate_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    passed_d = 1'b0;
`ifdef EXIT_TIMEOUT_EN
    alarm_d  = alarm_q;
`endif
    case (state_q)
      IDLE: begin
        if (exit_req) begin
          slot_d  = exit_slot;
          ack_d   = 1'b1;
          state_d = CHECK;
`ifdef EXIT_TIMEOUT_EN
          alarm_d = 1'b0;
`endif
        end
      end
      CHECK: begin
        if (slot_ok) begin
          state_d = OPEN;
          rel_d   = 1'b1;
          mask_d  = slot_onehot;
          gate_d  = 1'b1;
        end else begin
          rej_d   = 1'b1;
          state_d = IDLE;
        end
      end
      OPEN: begin
        passed_d = pass_now;
        if (pass_now && hold_done) begin
          state_d = CLOSE;
          gate_d  = 1'b0;
          done_d  = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (timed_out) begin
          // Abandoned exit: close and flag it, but it is not a completed exit.
          state_d = CLOSE;
          gate_d  = 1'b0;
          done_d  = 1'b1;
`ifdef EXIT_TIMEOUT_EN
          alarm_d = 1'b1;
`endif
        end
      end
      CLOSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state, slot latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rel_q    <= 1'b0;
      mask_q   <= '0;
      rej_q    <= 1'b0;
      gate_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      passed_q <= 1'b0;
`ifdef EXIT_TIMEOUT_EN
      alarm_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      rel_q    <= rel_d;
      mask_q   <= mask_d;
      rej_q    <= rej_d;
      gate_q   <= gate_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      passed_q <= passed_d;
`ifdef EXIT_TIMEOUT_EN
      alarm_q  <= alarm_d;
`endif
    end
  end

  assign exit_ack     = ack_q;
  assign exit_busy    = busy_q;
  assign slot_release = rel_q;
  assign release_mask = mask_q;
  assign exit_reject  = rej_q;
  assign gate_open    = gate_q;
  assign exit_done    = done_q;
  assign exit_count   = cnt_q;
`ifdef EXIT_TIMEOUT_EN
  assign exit_alarm   = alarm_q;
`else
  assign exit_alarm   = 1'b0;
`endif

endmodule

// File: tb/tb_exit_controller.sv
// Directed bench for exit_controller (GATE_HOLD=16, TIMEOUT=255).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Timeout scenario follows EXIT_TIMEOUT_EN when defined.
module tb_exit_controller;
  import parking_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 exit_req = 1'b0;
  logic [SLOT_W-1:0]    exit_slot = '0;
  logic [NUM_SLOTS-1:0] occupancy = '0;
  logic                 car_passed = 1'b0;
  logic                 exit_ack, exit_busy, slot_release, exit_reject;
  logic                 gate_open, exit_done, exit_alarm;
  logic [NUM_SLOTS-1:0] release_mask;
  logic [15:0]          exit_count;

  int n_chk  = 0;
  int n_fail = 0;

  exit_controller #(
    .GATE_HOLD (16),
    .TIMEOUT   (255),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exit_req     (exit_req),
    .exit_slot    (exit_slot),
    .occupancy    (occupancy),
    .car_passed   (car_passed),
    .exit_ack     (exit_ack),
    .exit_busy    (exit_busy),
    .slot_release (slot_release),
    .release_mask (release_mask),
    .exit_reject  (exit_reject),
    .gate_open    (gate_open),
    .exit_done    (exit_done),
    .exit_count   (exit_count),
    .exit_alarm   (exit_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic try_reject(input logic [SLOT_W-1:0] s, input logic [NUM_SLOTS-1:0] occ);
    occupancy = occ;
    exit_slot = s;
    exit_req  = 1'b1;
    tick();
    chk("rej_ack", exit_ack, 1);
    exit_req = 1'b0;
    tick();
    chk("rej_pulse", exit_reject, 1);
    chk("rej_no_release", slot_release, 0);
    chk("rej_mask", release_mask, 0);
    chk("rej_gate", gate_open, 0);
    tick();
    chk("rej_pulse_end", exit_reject, 0);
    chk("rej_idle", exit_busy, 0);
    chk("rej_gate_after", gate_open, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int gcnt;
    int n;
    int extra_acks;
    bit done;

    // Reset state
    #3;
    chk("rst_busy", exit_busy, 0);
    chk("rst_gate", gate_open, 0);
    chk("rst_ack", exit_ack, 0);
    chk("rst_release", slot_release, 0);
    chk("rst_mask", release_mask, 0);
    chk("rst_reject", exit_reject, 0);
    chk("rst_done", exit_done, 0);
    chk("rst_count", exit_count, 0);
    chk("rst_alarm", exit_alarm, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Valid exit of slot 5
    occupancy = 8'hFF;
    exit_slot = 3'd5;
    exit_req  = 1'b1;
    tick();
    chk("t1_ack", exit_ack, 1);
    chk("t1_busy", exit_busy, 1);
    chk("t1_gate_check", gate_open, 0);
    chk("t1_no_early_rel", slot_release, 0);
    exit_req = 1'b0;
    tick();
    chk("t1_release", slot_release, 1);
    chk("t1_mask", release_mask, 8'h20);
    chk("t1_gate", gate_open, 1);
    chk("t1_ack_end", exit_ack, 0);
    tick();
    chk("t1_release_end", slot_release, 0);
    chk("t1_mask_end", release_mask, 0);
    chk("t1_gate_hold", gate_open, 1);

    // Car passes at OPEN cycle 3; gate stays open 16 cycles
    chk("t3_count_before", exit_count, 0);
    gcnt = 2;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      car_passed = (gcnt == 4);
      tick();
      if (gate_open) gcnt++;
      if (exit_done) done = 1;
    end
    car_passed = 1'b0;
    chk("t3_done_seen", done, 1);
    chk("t3_gate_cycles", gcnt, 16);
    chk("t3_gate_closed", gate_open, 0);
    chk("t3_count", exit_count, 1);
    tick();
    chk("t3_done_end", exit_done, 0);
    chk("t3_idle", exit_busy, 0);

    // Held request: ignored while busy, re-accepted after IDLE entry
    exit_slot  = 3'd5;
    exit_req   = 1'b1;
    car_passed = 1'b1;
    tick();
    chk("t4_ack", exit_ack, 1);
    n = 0;
    extra_acks = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      n++;
      if (exit_ack) extra_acks++;
      if (exit_done) done = 1;
    end
    chk("t4_min_len", n, 17);
    chk("t4_no_ack_busy", extra_acks, 0);
    chk("t4_count", exit_count, 2);
    tick();
    chk("t4_idle", exit_busy, 0);
    chk("t4_no_ack_idle", exit_ack, 0);
    tick();
    chk("t4_reaccept", exit_ack, 1);
    chk("t4_rebusy", exit_busy, 1);
    exit_req   = 1'b0;
    car_passed = 1'b0;
    tick();
    chk("t5_gate_open", gate_open, 1);
    tick();
    tick();

    // Reset while OPEN
    rst_n = 1'b0;
    #1;
    chk("t5_gate", gate_open, 0);
    chk("t5_busy", exit_busy, 0);
    chk("t5_count", exit_count, 0);
    chk("t5_release", slot_release, 0);
    chk("t5_done", exit_done, 0);
    chk("t5_ack", exit_ack, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Rejects: slot 5 vacant, and lowest slot vacant
    try_reject(3'd5, 8'hDF);
    try_reject(3'd0, 8'hFE);

    // Highest slot, no car ever passes
    occupancy = 8'h80;
    exit_slot = 3'd7;
    exit_req  = 1'b1;
    tick();
    chk("t6_ack", exit_ack, 1);
    exit_req = 1'b0;
    tick();
    chk("t6_release", slot_release, 1);
    chk("t6_mask", release_mask, 8'h80);
    chk("t6_gate", gate_open, 1);
`ifdef EXIT_TIMEOUT_EN
    gcnt = 1;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (gate_open) gcnt++;
      if (exit_done) done = 1;
    end
    chk("t6_done_seen", done, 1);
    chk("t6_open_cycles", gcnt, 255);
    chk("t6_alarm", exit_alarm, 1);
    chk("t6_count_same", exit_count, 0);
    chk("t6_gate_closed", gate_open, 0);
    tick();
    chk("t6_alarm_sticky", exit_alarm, 1);
    chk("t6_idle", exit_busy, 0);
    occupancy = 8'hFF;
    exit_slot = 3'd1;
    exit_req  = 1'b1;
    tick();
    exit_req = 1'b0;
    chk("t6_ack2", exit_ack, 1);
    chk("t6_alarm_clear", exit_alarm, 0);
`else
    repeat (300) tick();
    chk("t6_still_open", gate_open, 1);
    chk("t6_still_busy", exit_busy, 1);
    chk("t6_no_alarm", exit_alarm, 0);
    chk("t6_no_done", exit_done, 0);
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    chk("t6_done", exit_done, 1);
    chk("t6_gate_closed", gate_open, 0);
    chk("t6_count", exit_count, 1);
    tick();
    chk("t6_idle", exit_busy, 0);
    chk("t6_alarm_idle", exit_alarm, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
